// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_t;

    localparam int PORT_PIPE = 0;
    localparam int PORT_AUX  = 1;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_STARVE_MAX = 4;
    localparam int SC_W           = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive port-1 denials.
// at_max reports that the value being loaded this edge equals STARVE_MAX.
module starve_counter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            clr,
    output logic [SC_W-1:0] sc,
    output logic            at_max
);

    localparam logic [SC_W-1:0] MAX_C = SC_W'(STARVE_MAX);

    logic [SC_W-1:0] sc_next;

    always_comb begin
        sc_next = sc;
        if (clr) begin
            sc_next = '0;
        end else if (inc && (sc != MAX_C)) begin
            sc_next = sc + 1'b1;
        end
        at_max = (sc_next == MAX_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sc <= '0;
        end else begin
            sc <= sc_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates memory2c between the pipeline (port 0, priority) and an aux agent
// (port 1), with a starvation-forced grant and registered read return.
//
// state  | meaning
// NORMAL | port 0 wins whenever it requests; port 1 takes idle cycles
// FORCE  | one cycle reserved for port 1 after STARVE_MAX denials
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_flush,
    output logic              p0_gnt,
    output logic              p0_stall,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t      state, state_next;
    logic            r0, r1;
    logic [1:0]      gnt;
    logic            sc_inc, sc_clr, sc_at_max;
    logic [SC_W-1:0] sc;
    logic            p0_rvalid_q, p1_rvalid_q;

    assign r0 = p0_req & ~p0_flush;
    assign r1 = p1_req;

    always_comb begin
        gnt        = 2'b00;
        state_next = state;
        case (state)
            NORMAL: begin
                gnt[PORT_PIPE] = r0;
                gnt[PORT_AUX]  = r1 & ~r0;
                if (sc_at_max) begin
                    state_next = FORCE;
                end
            end
            FORCE: begin
                gnt[PORT_AUX] = r1;
                state_next    = NORMAL;
            end
            default: begin
                state_next = NORMAL;
            end
        endcase
    end

    assign p0_gnt   = gnt[PORT_PIPE];
    assign p1_gnt   = gnt[PORT_AUX];
    assign p0_stall = r0 & ~p0_gnt;

    assign sc_inc = r1 & ~p1_gnt;
    assign sc_clr = p1_gnt | ~r1;

    starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (sc_inc),
        .clr    (sc_clr),
        .sc     (sc),
        .at_max (sc_at_max)
    );

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        mem_en    = p0_gnt | p1_gnt;
        if (p0_gnt) begin
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_wr    = p0_wr;
        end else if (p1_gnt) begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_wr    = p1_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= NORMAL;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
        end else begin
            state       <= state_next;
            p0_rvalid_q <= p0_gnt & ~p0_wr;
            p1_rvalid_q <= p1_gnt & ~p1_wr;
            if (p0_gnt && !p0_wr) begin
                p0_rdata <= mem_rdata;
            end
            if (p1_gnt && !p1_wr) begin
                p1_rdata <= mem_rdata;
            end
        end
    end

    // A reset landing the cycle after a read grant must still kill that pulse.
    assign p0_rvalid = p0_rvalid_q & ~rst;
    assign p1_rvalid = p1_rvalid_q & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory2c model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_wr, p0_flush;
    logic [15:0] p0_addr, p0_wdata;
    logic        p0_gnt, p0_stall, p0_rvalid;
    logic [15:0] p0_rdata;
    logic        p1_req, p1_wr;
    logic [15:0] p1_addr, p1_wdata;
    logic        p1_gnt, p1_rvalid;
    logic [15:0] p1_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, mem_en;

    logic [15:0] tb_mem [0:255];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_wr) tb_mem[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = tb_mem[mem_addr[7:0]];

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_flush(p0_flush), .p0_gnt(p0_gnt), .p0_stall(p0_stall),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_en(mem_en), .mem_rdata(mem_rdata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic wr, input logic [15:0] a, input logic [15:0] d);
        p0_req = req; p0_wr = wr; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set_p1(input logic req, input logic wr, input logic [15:0] a, input logic [15:0] d);
        p1_req = req; p1_wr = wr; p1_addr = a; p1_wdata = d;
    endtask

    task automatic idle();
        set_p0(1'b0, 1'b0, 16'h0, 16'h0);
        set_p1(1'b0, 1'b0, 16'h0, 16'h0);
        p0_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_p0(1'b1, 1'b0, 16'h0005, 16'h0);
        set_p1(1'b1, 1'b0, 16'h0006, 16'h0);
        #2;
        checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++;
            $display("FAIL reset_grant: p0_gnt=%b p1_gnt=%b required 1/0", p0_gnt, p1_gnt); end
        cyc();
        #2;
        checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin errors++;
            $display("FAIL reset_rvalid_hold: p0=%b p1=%b required 0/0", p0_rvalid, p1_rvalid); end
        cyc();
        rst = 1'b0;
        idle();
        #2;
        checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin errors++;
            $display("FAIL reset_rvalid: p0=%b p1=%b required 0/0", p0_rvalid, p1_rvalid); end
        checks++; if (p0_rdata !== 16'h0 || p1_rdata !== 16'h0) begin errors++;
            $display("FAIL reset_rdata: p0=%h p1=%h required 0000/0000", p0_rdata, p1_rdata); end
        checks++; if (dut.u_starve.sc !== 4'd0 || dut.state !== NORMAL) begin errors++;
            $display("FAIL reset_sc_state: sc=%0d state=%0d required 0/NORMAL", dut.u_starve.sc, dut.state); end
        cyc();
    endtask

    task automatic test_p0_write_read();
        set_p0(1'b1, 1'b1, 16'h0010, 16'h00A5);
        #2;
        checks++; if (p0_gnt !== 1'b1 || p0_stall !== 1'b0) begin errors++;
            $display("FAIL p0_wr_gnt: gnt=%b stall=%b required 1/0", p0_gnt, p0_stall); end
        checks++; if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'h00A5) begin errors++;
            $display("FAIL p0_wr_mux: en=%b wr=%b addr=%h wdata=%h required 1/1/0010/00A5", mem_en, mem_wr, mem_addr, mem_wdata); end
        cyc();
        p0_wr = 1'b0;
        #2;
        checks++; if (p0_gnt !== 1'b1 || p0_stall !== 1'b0 || mem_wr !== 1'b0) begin errors++;
            $display("FAIL p0_rd_gnt: gnt=%b stall=%b mem_wr=%b required 1/0/0", p0_gnt, p0_stall, mem_wr); end
        checks++; if (p0_rvalid !== 1'b0) begin errors++;
            $display("FAIL p0_wr_no_rvalid: rvalid=%b required 0", p0_rvalid); end
        cyc();
        idle();
        #2;
        checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 16'h00A5) begin errors++;
            $display("FAIL p0_rd_data: rvalid=%b rdata=%h required 1/00A5", p0_rvalid, p0_rdata); end
        cyc();
        #2;
        checks++; if (p0_rvalid !== 1'b0 || p0_rdata !== 16'h00A5) begin errors++;
            $display("FAIL p0_rd_hold: rvalid=%b rdata=%h required 0/00A5", p0_rvalid, p0_rdata); end
        cyc();
    endtask

    task automatic test_starvation();
        set_p0(1'b1, 1'b0, 16'h0010, 16'h0);
        set_p1(1'b1, 1'b0, 16'h0011, 16'h0);
        for (int c = 1; c <= 8; c++) begin
            #2;
            checks++; if (p1_gnt !== (c == 5) || p0_gnt !== (c != 5) || p0_stall !== (c == 5)) begin errors++;
                $display("FAIL starve_c%0d: p1_gnt=%b p0_gnt=%b stall=%b required %b/%b/%b",
                         c, p1_gnt, p0_gnt, p0_stall, c == 5, c != 5, c == 5); end
            checks++; if (p0_rvalid !== (c >= 2 && c != 6)) begin errors++;
                $display("FAIL starve_p0rv_c%0d: rvalid=%b required %b", c, p0_rvalid, c >= 2 && c != 6); end
            if (c == 6) begin
                checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 16'hC011) begin errors++;
                    $display("FAIL starve_p1_read: rvalid=%b rdata=%h required 1/C011", p1_rvalid, p1_rdata); end
            end
            cyc();
        end
        idle();
        cyc();
        #2;
        checks++; if (dut.u_starve.sc !== 4'd0 || dut.state !== NORMAL) begin errors++;
            $display("FAIL starve_sc_clear: sc=%0d state=%0d required 0/NORMAL", dut.u_starve.sc, dut.state); end
        cyc();
    endtask

    task automatic test_flush();
        set_p0(1'b1, 1'b1, 16'h0020, 16'h1234);
        cyc();
        set_p0(1'b1, 1'b1, 16'h0020, 16'hBEEF);
        p0_flush = 1'b1;
        set_p1(1'b1, 1'b0, 16'h0020, 16'h0);
        #2;
        checks++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || p0_stall !== 1'b0) begin errors++;
            $display("FAIL flush_gnt: p1_gnt=%b p0_gnt=%b stall=%b required 1/0/0", p1_gnt, p0_gnt, p0_stall); end
        checks++; if (mem_wr !== 1'b0 || mem_addr !== 16'h0020) begin errors++;
            $display("FAIL flush_mux: mem_wr=%b addr=%h required 0/0020", mem_wr, mem_addr); end
        cyc();
        idle();
        #2;
        checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 16'h1234 || p0_rvalid !== 1'b0) begin errors++;
            $display("FAIL flush_old_data: p1_rvalid=%b p1_rdata=%h p0_rvalid=%b required 1/1234/0", p1_rvalid, p1_rdata, p0_rvalid); end
        // a flush right after a granted read must not eat that read's rvalid
        set_p0(1'b1, 1'b0, 16'h0010, 16'h0);
        cyc();
        p0_flush = 1'b1;
        #2;
        checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 16'h00A5 || p0_gnt !== 1'b0) begin errors++;
            $display("FAIL flush_after_read: rvalid=%b rdata=%h gnt=%b required 1/00A5/0", p0_rvalid, p0_rdata, p0_gnt); end
        cyc();
        idle();
        #2;
        checks++; if (p0_rvalid !== 1'b0) begin errors++;
            $display("FAIL flush_no_rvalid: rvalid=%b required 0", p0_rvalid); end
        cyc();
    endtask

    task automatic test_withdrawal();
        set_p0(1'b1, 1'b0, 16'h0010, 16'h0);
        set_p1(1'b1, 1'b0, 16'h0011, 16'h0);
        for (int k = 1; k <= 3; k++) begin
            #2;
            checks++; if (p1_gnt !== 1'b0) begin errors++;
                $display("FAIL wd_deny_%0d: p1_gnt=%b required 0", k, p1_gnt); end
            cyc();
        end
        p1_req = 1'b0;
        #2;
        checks++; if (dut.u_starve.sc !== 4'd3) begin errors++;
            $display("FAIL wd_sc3: sc=%0d required 3", dut.u_starve.sc); end
        cyc();
        p1_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            #2;
            checks++; if (p1_gnt !== (k == 5) || dut.u_starve.sc !== 4'(k - 1)) begin errors++;
                $display("FAIL wd_rereq_%0d: p1_gnt=%b sc=%0d required %b/%0d", k, p1_gnt, dut.u_starve.sc, k == 5, k - 1); end
            cyc();
        end
        idle();
        cyc();
    endtask

    task automatic test_back_to_back();
        set_p1(1'b1, 1'b1, 16'h0030, 16'h7777);
        #2;
        checks++; if (p1_gnt !== 1'b1 || mem_wr !== 1'b1 || mem_wdata !== 16'h7777) begin errors++;
            $display("FAIL b2b_p1_write: gnt=%b mem_wr=%b wdata=%h required 1/1/7777", p1_gnt, mem_wr, mem_wdata); end
        cyc();
        set_p1(1'b0, 1'b0, 16'h0, 16'h0);
        set_p0(1'b1, 1'b0, 16'h0030, 16'h0);
        #2;
        checks++; if (p1_rvalid !== 1'b0 || p0_gnt !== 1'b1) begin errors++;
            $display("FAIL b2b_gnt: p1_rvalid=%b p0_gnt=%b required 0/1", p1_rvalid, p0_gnt); end
        cyc();
        idle();
        #2;
        checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 16'h7777) begin errors++;
            $display("FAIL b2b_read_new: rvalid=%b rdata=%h required 1/7777", p0_rvalid, p0_rdata); end
        cyc();
    endtask

    task automatic test_reset_mid_read();
        set_p1(1'b1, 1'b0, 16'h0012, 16'h0);
        #2;
        checks++; if (p1_gnt !== 1'b1 || mem_en !== 1'b1) begin errors++;
            $display("FAIL rmr_gnt: p1_gnt=%b mem_en=%b required 1/1", p1_gnt, mem_en); end
        cyc();
        rst = 1'b1;
        idle();
        #2;
        checks++; if (p1_rvalid !== 1'b0) begin errors++;
            $display("FAIL rmr_rvalid_in_rst: rvalid=%b required 0", p1_rvalid); end
        cyc();
        rst = 1'b0;
        #2;
        checks++; if (p1_rvalid !== 1'b0 || dut.u_starve.sc !== 4'd0 || dut.state !== NORMAL) begin errors++;
            $display("FAIL rmr_after: rvalid=%b sc=%0d state=%0d required 0/0/NORMAL", p1_rvalid, dut.u_starve.sc, dut.state); end
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 16'hC000 | 16'(i);
        rst = 1'b1;
        idle();
        cyc();
        test_reset();
        test_p0_write_read();
        test_starvation();
        test_flush();
        test_withdrawal();
        test_back_to_back();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported data memory (`memory2c`) between two requesters: port 0, the pipeline memory stage, and port 1, a secondary agent such as the board/IO loader or display scanner.
- Port 0 has priority. A saturating starvation counter forces one port-1 grant after `STARVE_MAX` consecutive denials.
- Read data is returned registered, one cycle after grant.
- The block sits between the memory stage and `memory2c` and drives its addr/data_in/wr/enable.

## Interface
Parameters:
- `ADDR_W`, 16, memory address width.
- `DATA_W`, 16, memory data width.
- `STARVE_MAX`, 4, denied port-1 cycles before forced grant; legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `p0_req`, `p0_wr`  in  1  pipeline request; 1 = write, 0 = read.
- `p0_addr`  in  ADDR_W  pipeline address.
- `p0_wdata`  in  DATA_W  pipeline write data.
- `p0_flush`  in  1  cancels this cycle's port-0 request.
- `p0_gnt`, `p0_stall`  out  1  port-0 granted this cycle / request pending but denied.
- `p0_rvalid`  out  1  port-0 read data valid (one-cycle pulse).
- `p0_rdata`  out  DATA_W  port-0 read data.
- `p1_req`, `p1_wr`, `p1_addr`, `p1_wdata`  in  same widths as port 0  secondary request.
- `p1_gnt`, `p1_rvalid`  out  1  port-1 grant / read valid.
- `p1_rdata`  out  DATA_W  port-1 read data.
- `mem_addr`, `mem_wdata`  out  ADDR_W / DATA_W  to memory addr / data_in.
- `mem_wr`, `mem_en`  out  1  to memory wr / enable.
- `mem_rdata`  in  DATA_W  memory data_out; combinational read.

## Operation
- Effective port-0 request: `r0 = p0_req & ~p0_flush`. Port-1 request: `r1 = p1_req`.
- Grant is combinational and one-hot or zero:
  - State NORMAL: `r0` wins; else `r1` wins.
  - State FORCE: `r1` wins; `p0_stall = r0`.
- `p0_stall = r0 & ~p0_gnt`.
- Memory mux:
  - Outputs carry the granted port's addr, wdata and wr.
  - `mem_en` = any grant; `mem_wr` = granted & wr.
  - With no grant, addr and wdata are 0 and `mem_wr = 0`.
- Read return: on a granted read, `mem_rdata` is captured at the edge into that port's `rdata` register, and `rvalid` pulses the following cycle. `rdata` holds its value until that port's next read. Writes produce no `rvalid`.
- Starvation counter `sc` (4 bits):
  - `sc` increments when `r1 & ~p1_gnt`, saturating at `STARVE_MAX`.
  - `sc` clears when `p1_gnt` or `~r1`.
- FSM states and transitions:
  - NORMAL → FORCE when the next value of `sc` equals `STARVE_MAX`.
  - FORCE → NORMAL after exactly one cycle, since port 1 is granted in FORCE.
  - FORCE with `~r1` (port 1 withdrew) → NORMAL, no grant to port 1.
- Requester rule: hold req, wr, addr and wdata stable until the grant. Dropping req while denied is legal and is treated as a withdrawal.
- Flush: a flushed port-0 request gets no grant, no write and no `rvalid`. A flush arriving on the cycle after a granted read does not suppress that read's `rvalid`.

## Timing
- Reset values:
  - Registers: `sc = 0`, state = NORMAL, both rdata = 0, both rvalid = 0.
  - Combinational outputs follow their equations from the reset state; grants are still issued during `rst` high, but no register updates.
- Grant latency: 0 cycles (same cycle as the request) when the port wins. Port-1 worst-case wait under continuous `r0` is `STARVE_MAX` cycles.
- Read latency: `rvalid` is asserted the cycle after the grant. Write takes effect at the grant-cycle edge.
- Simultaneous events:
  - Both ports request in NORMAL: port 0 wins and port 1 is denied.
  - Same-address write by one port and read by the other in consecutive cycles: the read sees the new data.
- Reset mid-operation: any pending `rvalid` is dropped, `sc` is cleared and state returns to NORMAL.

## Structure
- Package `mem_arb_pkg` holds:
  - State enum `arb_state_t` {NORMAL, FORCE}.
  - Port-ID constants `PORT_PIPE = 0`, `PORT_AUX = 1`.
  - Default widths.
- One sub-module, `starve_counter`: saturating counter with inc/clr inputs and an `at_max` output, parameterized by `STARVE_MAX`.
- Grant logic, memory mux and read-return registers stay in the top level.

## Test plan
- Reset: hold `rst` 2 cycles with both ports requesting → all rvalid = 0 and all rdata = 0 after reset; `sc = 0`.
- Port-0 write then read: write 0x00A5 to 0x0010, then read 0x0010 → `p0_gnt` in both cycles; `p0_rvalid` the cycle after the read with `p0_rdata = 0x00A5`; `p0_stall` stays 0.
- Contention and starvation (`STARVE_MAX = 4`): `r0` and `r1` held high for 8 cycles → `p1_gnt` only in cycle 5; `p0_stall = 1` only in cycle 5; `sc` returns to 0 afterwards.
- Flush: `p0_req = 1` with `p0_flush = 1` writing 0xBEEF to 0x0020, `p1_req` reading 0x0020 → `p1_gnt = 1`, `mem_wr = 0`; the port-1 read returns the old value.
- Withdrawal: port 1 is denied 3 cycles, drops req for 1 cycle, then re-requests under continuous `r0` → `sc` restarts from 0; forced grant occurs 4 denied cycles later.
- Reset mid-read: assert `rst` on the cycle after a port-1 read grant → `p1_rvalid` stays 0.
